// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: state encoding and protocol constants.
package spi_pkg;

  localparam int unsigned SPI_BYTE_BITS   = 8;
  localparam int unsigned SPI_MIN_DIVIDER = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_controller_state_t;

endpackage

// File: rtl/spi_controller_timer.sv
// Half-period counter for the SPI initiator; owns the SCK level and its strobes.
module spi_controller_timer #(
  parameter int unsigned DIVIDER = 4
) (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic run,
  input  logic shift,
  input  logic stall,
  output logic phase_end,
  output logic sck_rise,
  output logic sck
);

  localparam int unsigned CW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] count;

  assign phase_end = run && !stall && (count == LAST);
  assign sck_rise  = phase_end && shift && !sck;

  // A stall parks the counter at the start of a low phase so shifting resumes cleanly.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      count <= '0;
      sck   <= 1'b0;
    end else begin
      if (!run || stall || phase_end) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      if (!shift || stall) begin
        sck <= 1'b0;
      end else if (phase_end) begin
        sck <= ~sck;
      end
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Mode-0 MSB-first SPI initiator: opcode, operand bytes, then response bytes per transaction.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned DIVIDER = 4
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       start_in,
  input  logic [7:0] opcode_in,
  input  logic [7:0] tx_count_in,
  input  logic [7:0] rx_count_in,
  input  logic [7:0] operand_in,
  input  logic       operand_valid_in,
  output logic       operand_ready_out,
  output logic [7:0] response_out,
  output logic       response_valid_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       spi_select_out,
  output logic       spi_clock_out,
  output logic       spi_data_out,
  input  logic       spi_data_in
);

  localparam int unsigned DIV = (DIVIDER < SPI_MIN_DIVIDER) ? SPI_MIN_DIVIDER : DIVIDER;
  localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_BITS - 1);

  spi_controller_state_t state;

  logic [6:0] tx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] ops_left;
  logic [7:0] rx_left;
  logic [7:0] rx_shift;
  logic [7:0] operand_q;
  logic [7:0] next_operand;
  logic       rx_byte;
  logic       operand_full;
  logic       stall;
  logic       resp_pending;
  logic       phase_end;
  logic       sck_rise;
  logic       sck;
  logic       take;
  logic       bit_end;
  logic       can_load;
  logic       timer_run;
  logic       timer_shift;

  assign take         = operand_valid_in && operand_ready_out;
  assign next_operand = operand_full ? operand_q : operand_in;
  assign can_load     = operand_full || take;
  assign bit_end      = (state == ST_SHIFT) && phase_end && sck;
  assign timer_run    = (state != ST_IDLE);
  assign timer_shift  = (state == ST_SHIFT);
  assign spi_clock_out = sck;

  spi_controller_timer #(
    .DIVIDER(DIV)
  ) u_timer (
    .clock_in  (clock_in),
    .reset_n_in(reset_n_in),
    .run       (timer_run),
    .shift     (timer_shift),
    .stall     (stall),
    .phase_end (phase_end),
    .sck_rise  (sck_rise),
    .sck       (sck)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state              <= ST_IDLE;
      tx_shift           <= '0;
      bit_cnt            <= '0;
      ops_left           <= '0;
      rx_left            <= '0;
      rx_shift           <= '0;
      operand_q          <= '0;
      rx_byte            <= 1'b0;
      operand_full       <= 1'b0;
      stall              <= 1'b0;
      resp_pending       <= 1'b0;
      operand_ready_out  <= 1'b0;
      response_out       <= '0;
      response_valid_out <= 1'b0;
      busy_out           <= 1'b0;
      done_out           <= 1'b0;
      spi_select_out     <= 1'b1;
      spi_data_out       <= 1'b0;
    end else begin
      // The completed byte is presented one cycle after its last bit was sampled.
      response_valid_out <= resp_pending;
      resp_pending       <= 1'b0;
      if (resp_pending) begin
        response_out <= rx_shift;
      end
      done_out <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_in) begin
            tx_shift       <= opcode_in[6:0];
            spi_data_out   <= opcode_in[7];
            bit_cnt        <= LAST_BIT;
            ops_left       <= tx_count_in;
            rx_left        <= rx_count_in;
            rx_byte        <= 1'b0;
            operand_full   <= 1'b0;
            stall          <= 1'b0;
            spi_select_out <= 1'b0;
            busy_out       <= 1'b1;
            state          <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (phase_end) begin
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (sck_rise) begin
            rx_shift <= {rx_shift[6:0], spi_data_in};
            if (bit_cnt == '0 && rx_byte) begin
              resp_pending <= 1'b1;
            end
          end
          if (take) begin
            operand_ready_out <= 1'b0;
          end
          // While stalled, the byte that was waiting for an operand starts on the transfer.
          if (stall) begin
            if (take) begin
              tx_shift     <= operand_in[6:0];
              spi_data_out <= operand_in[7];
              bit_cnt      <= LAST_BIT;
              ops_left     <= ops_left - 8'd1;
              stall        <= 1'b0;
            end
          end else if (bit_end) begin
            if (bit_cnt != '0) begin
              bit_cnt      <= bit_cnt - 1'b1;
              spi_data_out <= tx_shift[6];
              tx_shift     <= {tx_shift[5:0], 1'b0};
              if (bit_cnt == 3'd1 && ops_left != '0) begin
                operand_ready_out <= 1'b1;
              end
            end else if (ops_left != '0) begin
              if (can_load) begin
                tx_shift     <= next_operand[6:0];
                spi_data_out <= next_operand[7];
                bit_cnt      <= LAST_BIT;
                ops_left     <= ops_left - 8'd1;
                operand_full <= 1'b0;
              end else begin
                stall <= 1'b1;
              end
            end else if (rx_left != '0) begin
              rx_left      <= rx_left - 8'd1;
              rx_byte      <= 1'b1;
              tx_shift     <= '0;
              spi_data_out <= 1'b0;
              bit_cnt      <= LAST_BIT;
            end else begin
              state <= ST_HOLD;
            end
          end else if (take) begin
            operand_q    <= operand_in;
            operand_full <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (phase_end) begin
            spi_select_out <= 1'b1;
            spi_data_out   <= 1'b0;
            state          <= ST_GAP;
          end
        end

        ST_GAP: begin
          // The done cycle is still part of GAP, so a start seen there is ignored.
          if (done_out) begin
            state <= ST_IDLE;
          end else if (phase_end) begin
            done_out <= 1'b1;
            busy_out <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
